// File: rtl/byte_load_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : byte_load_seq_pkg
// Description : Shared definitions for the byte-serial load sequencer.
//               Holds the load size encodings, the sequencer state encoding
//               and helpers for the byte count and alignment test.
// Revision    : 1.0 - initial release
// ============================================================================
package byte_load_seq_pkg;

    // Load size encodings as presented on req_size
    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Number of bytes transferred for a given size; 0 for the illegal code
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // A request is rejected when it is not naturally aligned or the size
    // code is illegal
    function automatic logic is_bad_request(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_load_seq_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_ext
// Description : Combinational sign/zero extender for assembled load data.
//               Ports:
//                 i_asm    [31:0] little-endian assembled bytes
//                 i_size   [1:0]  load size code
//                 i_signed        1 = sign-extend, 0 = zero-extend
//                 o_data   [31:0] extended result (0 for illegal size)
// Revision    : 1.0 - initial release
// ============================================================================
module load_ext
    import byte_load_seq_pkg::*;
(
    input  logic [31:0] i_asm,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = '0;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_signed & i_asm[7]}},  i_asm[7:0]};
            SZ_HALF: o_data = {{16{i_signed & i_asm[15]}}, i_asm[15:0]};
            SZ_WORD: o_data = i_asm;
            default: o_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/byte_load_seq.sv
`default_nettype none
// ============================================================================
// Module      : byte_load_seq
// Description : Fetches a byte/halfword/word load one byte at a time from a
//               byte-wide memory, assembles it little-endian, extends it to
//               32 bits and returns it with a single-cycle response strobe.
//               Ports:
//                 clk, rst_n                 clock, async active-low reset
//                 req_valid/req_ready        request handshake
//                 req_addr/req_size/req_signed  request fields
//                 mem_rd_en/mem_addr         byte read command
//                 mem_rdata                  read data, one cycle after rd_en
//                 resp_valid/resp_data/resp_err  response
// Revision    : 1.0 - initial release
// ============================================================================
module byte_load_seq
    import byte_load_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    logic [1:0]  r_state;
    logic [31:0] r_base;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [2:0]  r_nbytes;
    logic [2:0]  r_count;
    logic [31:0] r_asm;

    logic        r_req_ready;
    logic        r_mem_rd_en;
    logic [31:0] r_mem_addr;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_req_bad;
    logic [2:0]  w_count_inc;
    logic [31:0] w_asm_next;
    logic [31:0] w_ext_data;

    assign w_accept    = req_valid & r_req_ready;
    assign w_req_bad   = is_bad_request(req_size, req_addr[1:0]);
    assign w_count_inc = r_count + 3'd1;

    // Assembly register with the byte arriving this cycle merged into its
    // lane. The extender works on this merged view so the final byte is
    // included in the response registered on the way into DONE.
    always_comb begin
        w_asm_next = r_asm;
        case (r_count[1:0])
            2'd0: w_asm_next[7:0]   = mem_rdata;
            2'd1: w_asm_next[15:8]  = mem_rdata;
            2'd2: w_asm_next[23:16] = mem_rdata;
            default: w_asm_next[31:24] = mem_rdata;
        endcase
    end

    load_ext u_load_ext (
        .i_asm    (w_asm_next),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_ext_data)
    );

    // Response registers are loaded on the edge that enters DONE, so
    // resp_valid is high for exactly the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_base       <= '0;
            r_size       <= SZ_BYTE;
            r_signed     <= 1'b0;
            r_nbytes     <= '0;
            r_count      <= '0;
            r_asm        <= '0;
            r_req_ready  <= 1'b1;
            r_mem_rd_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_base      <= req_addr;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_nbytes    <= size_to_nbytes(req_size);
                        r_count     <= '0;
                        r_asm       <= '0;
                        if (w_req_bad) begin
                            // Rejected without touching memory
                            r_state      <= ST_DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_data  <= '0;
                        end else begin
                            r_state     <= ST_FETCH;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= req_addr;
                        end
                    end
                end
                ST_FETCH: begin
                    r_mem_rd_en <= 1'b0;
                    r_state     <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_asm   <= w_asm_next;
                    r_count <= w_count_inc;
                    if (w_count_inc == r_nbytes) begin
                        r_state      <= ST_DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_ext_data;
                        r_resp_err   <= 1'b0;
                    end else begin
                        r_state     <= ST_FETCH;
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= r_base + {29'd0, w_count_inc};
                    end
                end
                ST_DONE: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_rd_en  = r_mem_rd_en;
    assign mem_addr   = r_mem_addr;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_byte_load_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_load_seq
// Description : Self-checking bench for byte_load_seq. A byte-wide memory
//               model answers reads one cycle after mem_rd_en; a table of
//               load requests with hand-computed results is replayed, then
//               mid-operation reset and streaming requests are exercised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_load_seq;
    import byte_load_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:255];

    byte_load_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-wide memory: data for a strobed read appears the following cycle
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr[7:0]];
    end

    typedef struct {
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_reads;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  32'(req_ready),  32'd1);
        check({tag, "_mem_rd_en"},  32'(mem_rd_en),  32'd0);
        check({tag, "_mem_addr"},   mem_addr,        32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_data"},  resp_data,       32'd0);
        check({tag, "_resp_err"},   32'(resp_err),   32'd0);
    endtask

    // Issue one request and follow it until the sequencer is idle again
    task automatic run_vec(input vec_t v);
        int   exp_off;
        int   reads;
        int   resp_seen;
        logic prev_rd;
        logic ready_bad;
        exp_off   = v.exp_err ? 0 : 2 * v.exp_reads;
        reads     = 0;
        resp_seen = 0;
        prev_rd   = 1'b0;
        ready_bad = 1'b0;
        @(negedge clk);
        check("ready_before_accept", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int off = 0; off <= exp_off + 2; off++) begin
            if (mem_rd_en) begin
                check("rd_addr", mem_addr, v.addr + 32'(reads));
                check("rd_en_gap", 32'(prev_rd), 32'd0);
                reads++;
            end
            prev_rd = mem_rd_en;
            if (resp_valid) begin
                resp_seen++;
                check("resp_offset", 32'(off), 32'(exp_off));
                check("resp_data", resp_data, v.exp_data);
                check("resp_err", 32'(resp_err), 32'(v.exp_err));
            end
            if (off <= exp_off && req_ready) ready_bad = 1'b1;
            if (off == exp_off + 1) begin
                check("ready_after_resp", 32'(req_ready), 32'd1);
                check("resp_data_held", resp_data, v.exp_data);
            end
            @(posedge clk); #1;
        end
        check("read_count", 32'(reads), 32'(v.exp_reads));
        check("resp_count", 32'(resp_seen), 32'd1);
        check("ready_low_while_busy", 32'(ready_bad), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_q [$];
        int          acc_edges [$];
        logic        prev_ready;
        logic        quiet_bad;
        vec_t        v;

        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        mem[8'h10] = 8'h80;  mem[8'h11] = 8'h7F;
        mem[8'h22] = 8'hBC;  mem[8'h23] = 8'h9A;
        mem[8'h40] = 8'h78;  mem[8'h41] = 8'h56;
        mem[8'h42] = 8'h34;  mem[8'h43] = 8'h12;
        mem[8'hFC] = 8'h01;  mem[8'hFD] = 8'h02;
        mem[8'hFE] = 8'h03;  mem[8'hFF] = 8'h84;

        //          size        sgn   addr          exp_data      err   reads
        vecs[0] = '{SZ_BYTE,    1'b1, 32'h00000010, 32'hFFFFFF80, 1'b0, 1};
        vecs[1] = '{SZ_BYTE,    1'b0, 32'h00000010, 32'h00000080, 1'b0, 1};
        vecs[2] = '{SZ_HALF,    1'b1, 32'h00000022, 32'hFFFF9ABC, 1'b0, 2};
        vecs[3] = '{SZ_HALF,    1'b0, 32'h00000022, 32'h00009ABC, 1'b0, 2};
        vecs[4] = '{SZ_WORD,    1'b1, 32'h00000040, 32'h12345678, 1'b0, 4};
        vecs[5] = '{SZ_HALF,    1'b1, 32'h00000021, 32'h00000000, 1'b1, 0};
        vecs[6] = '{SZ_WORD,    1'b0, 32'h00000042, 32'h00000000, 1'b1, 0};
        vecs[7] = '{SZ_ILLEGAL, 1'b0, 32'h00000040, 32'h00000000, 1'b1, 0};
        vecs[8] = '{SZ_BYTE,    1'b1, 32'h00000011, 32'h0000007F, 1'b0, 1};
        vecs[9] = '{SZ_WORD,    1'b0, 32'hFFFFFFFC, 32'h84030201, 1'b0, 4};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_size   = SZ_BYTE;
        req_signed = 1'b0;
        mem_rdata  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset pulse during the third FETCH of a word load
        @(negedge clk);
        req_valid  = 1'b1;
        req_size   = SZ_WORD;
        req_signed = 1'b0;
        req_addr   = 32'h00000040;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("mid_third_fetch_rd_en", 32'(mem_rd_en), 32'd1);
        check("mid_third_fetch_addr", mem_addr, 32'h00000042);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk); #1;
        check_reset_outputs("held_reset");
        @(negedge clk);
        rst_n     = 1'b1;
        quiet_bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (resp_valid || mem_rd_en) quiet_bad = 1'b1;
        end
        check("no_activity_after_reset", 32'(quiet_bad), 32'd0);
        v = vecs[0];
        run_vec(v);

        // req_valid held high with alternating byte loads
        @(negedge clk);
        req_valid  = 1'b1;
        req_size   = SZ_BYTE;
        req_addr   = 32'h00000010;
        req_signed = 1'b1;
        prev_ready = req_ready;
        for (int e = 0; e < 32; e++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_orphan_resp", 32'(resp_valid), 32'd0);
                end else begin
                    check("stream_resp_data", resp_data, exp_q.pop_front());
                end
            end
            if (e < 26 && prev_ready) begin
                acc_edges.push_back(e);
                exp_q.push_back(req_addr == 32'h10 ? 32'hFFFFFF80 : 32'h0000007F);
                check("stream_ready_drop", 32'(req_ready), 32'd0);
                if (req_addr == 32'h10) begin
                    req_addr   = 32'h00000011;
                    req_signed = 1'b0;
                end else begin
                    req_addr   = 32'h00000010;
                    req_signed = 1'b1;
                end
            end
            if (e == 25) req_valid = 1'b0;
            prev_ready = req_ready && req_valid;
        end
        check("stream_accepts", 32'(acc_edges.size()), 32'd7);
        check("stream_pending", 32'(exp_q.size()), 32'd0);
        for (int i = 1; i < acc_edges.size(); i++)
            check("stream_period", 32'(acc_edges[i] - acc_edges[i-1]), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
